stream_burst_source: RTL and testbench
======================================

Name: stream_burst_source

Overview:
- Transmitter end of the team's valid/ready stream interface: on a start command, sends a burst of incrementing data words on the dn side.
- Drives the up_bus/up_val/up_rdy side of skid-register chains (e.g. axi_top) and acts as the traffic source at that end.
- Fully registered outputs. Obeys the hold-until-accepted rule under arbitrary backpressure.

Parameters:
- DATA_WIDTH, 7, width of dn_bus and first_val
- LEN_WIDTH, 8, width of burst_len and beats_sent; maximum burst 2^LEN_WIDTH-1 beats
- GAP, 0, idle cycles inserted after each accepted non-final beat (0 = back-to-back)

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- start  input  1  burst request; sampled only in IDLE
- first_val  input  DATA_WIDTH  data value of first beat; captured with start
- burst_len  input  LEN_WIDTH  number of beats; captured with start
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse after the burst completes
- beats_sent  output  LEN_WIDTH  count of accepted beats in current/last burst
- dn_bus  output  DATA_WIDTH  stream data
- dn_val  output  1  stream valid
- dn_rdy  input  1  stream ready from downstream

Behaviour:
- Reset (rst=0, immediate, asynchronous): state=IDLE; dn_val=0, dn_bus=0, busy=0, done=0, beats_sent=0, internal remaining/gap counters=0.
- Reset mid-burst aborts the burst. dn_val may drop without a handshake only under reset.
- Transfer = dn_val && dn_rdy at a rising edge.
- States: IDLE, SEND, WAIT (gap).
- IDLE:
  - done is 0 except the single cycle after burst completion.
  - start=1 sampled: beats_sent<=0, remaining<=burst_len.
  - If burst_len==0: stay IDLE, done=1 next cycle, dn_val stays 0.
  - Else: go to SEND; dn_val<=1, dn_bus<=first_val.
  - Latency start -> first dn_val = 1 cycle.
- SEND:
  - dn_val=1.
  - No transfer: dn_bus and dn_val hold exactly.
  - Transfer: beats_sent+1, remaining-1.
  - Final beat (remaining==1): dn_val<=0, go IDLE, done<=1 for one cycle.
  - Non-final beat, GAP==0: dn_bus<=dn_bus+1, stay SEND, dn_val stays 1 (one beat per cycle at full throughput).
  - Non-final beat, GAP>0: dn_val<=0, gap counter<=GAP, go to WAIT.
- WAIT:
  - dn_val=0; counter decrements each cycle.
  - On the cycle the counter reaches 1: go to SEND, dn_val<=1, dn_bus<=previous dn_bus+1.
  - Result: exactly GAP idle cycles between beats.
- Arithmetic: dn_bus increment wraps modulo 2^DATA_WIDTH. beats_sent never wraps (bounded by burst_len).
- busy is registered and matches state; done and busy are never high together.
- start while busy: ignored, no effect on the burst in progress.
- start in the cycle done=1 (state is IDLE): accepted; next burst's first dn_val follows 1 cycle later.
- No combinational path from dn_rdy or start to any output.
- dn_rdy may toggle freely, including while dn_val=0; the block ignores it then.
- first_val/burst_len changes after capture have no effect on the running burst.
- beats_sent holds its final value until the next accepted start or reset.

Test Plan:
- GAP=0, first_val=7'h7E, burst_len=4, dn_rdy=1, start at cycle 0 -> dn_val=1 in cycles 1-4 with dn_bus 7E,7F,00,01 (wrap); done=1 in cycle 5 only; beats_sent=4; busy high cycles 1-4.
- GAP=0, burst_len=3, first_val=5, dn_rdy low in cycles 2-4 -> dn_bus stays 6 and dn_val stays 1 through cycles 2-4; accepted sequence exactly 5,6,7; done one cycle after final transfer.
- burst_len=0, start at cycle 0 -> dn_val never rises; done=1 in cycle 1; busy stays 0; beats_sent=0.
- Start pulses in cycles 2 and 3 of a 4-beat burst -> ignored, still exactly 4 beats. A second start in the done cycle with first_val=0x10, burst_len=2 -> beats 0x10, 0x11 begin the next cycle.
- GAP=2, burst_len=3, first_val=0, dn_rdy=1 -> dn_val pattern 1,0,0,1,0,0,1 from cycle 1; data 0,1,2; done in cycle 8.
- rst driven low between edges during beat 2 of 5 -> dn_val, busy, done, beats_sent fall to 0 immediately with no clock edge. After release, a new start with burst_len=1 produces one beat and a done pulse.

Source files
------------

// File: rtl/stream_burst_source.sv
// Valid/ready burst source: on start, emits burst_len incrementing words on dn_*,
// holding each word until accepted and optionally idling GAP cycles between beats.
module stream_burst_source #(
  parameter int DATA_WIDTH = 7,
  parameter int LEN_WIDTH  = 8,
  parameter int GAP        = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] first_val,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  beats_sent,
  output logic [DATA_WIDTH-1:0] dn_bus,
  output logic                  dn_val,
  input  logic                  dn_rdy
);

  // state  | meaning
  // S_IDLE | no burst; start accepted here, done pulses here
  // S_SEND | dn_val high, word held until dn_rdy
  // S_WAIT | inter-beat gap, r_gap counts down to 1
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic [LEN_WIDTH-1:0]  r_beats;
  logic [LEN_WIDTH-1:0]  r_rem;
  logic [GAP_W-1:0]      r_gap;
  logic [DATA_WIDTH-1:0] r_bus;
  logic                  r_val;
  logic                  w_xfer;

  assign w_xfer = r_val && dn_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_beats <= '0;
      r_rem   <= '0;
      r_gap   <= '0;
      r_bus   <= '0;
      r_val   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_beats <= '0;
            r_rem   <= burst_len;
            if (burst_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= S_SEND;
              r_busy  <= 1'b1;
              r_val   <= 1'b1;
              r_bus   <= first_val;
            end
          end
        end
        S_SEND: begin
          if (w_xfer) begin
            r_beats <= r_beats + 1'b1;
            r_rem   <= r_rem - 1'b1;
            if (r_rem == LEN_WIDTH'(1)) begin
              r_val   <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else if (GAP == 0) begin
              r_bus <= r_bus + 1'b1;
            end else begin
              r_val   <= 1'b0;
              r_gap   <= GAP_W'(GAP);
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          r_gap <= r_gap - 1'b1;
          if (r_gap == GAP_W'(1)) begin
            r_state <= S_SEND;
            r_val   <= 1'b1;
            r_bus   <= r_bus + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_val   <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign beats_sent = r_beats;
  assign dn_bus     = r_bus;
  assign dn_val     = r_val;

endmodule

// File: tb/tb_stream_burst_source.sv
// Directed bench for stream_burst_source: one GAP=0 and one GAP=2 instance,
// accepted beats checked against a queue of expected words.
module tb_stream_burst_source;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       start0 = 1'b0, rdy0 = 1'b0;
  logic [6:0] fv0 = '0;
  logic [7:0] len0 = '0;
  logic       busy0, done0, val0;
  logic [7:0] beats0;
  logic [6:0] bus0;

  logic       start2 = 1'b0, rdy2 = 1'b0;
  logic [6:0] fv2 = '0;
  logic [7:0] len2 = '0;
  logic       busy2, done2, val2;
  logic [7:0] beats2;
  logic [6:0] bus2;

  int n_cmp = 0;
  int n_err = 0;
  logic [6:0] q0[$];
  logic [6:0] q2[$];

  stream_burst_source #(.DATA_WIDTH(7), .LEN_WIDTH(8), .GAP(0)) u_gap0 (
    .clk(clk), .rst(rst), .start(start0), .first_val(fv0), .burst_len(len0),
    .busy(busy0), .done(done0), .beats_sent(beats0), .dn_bus(bus0),
    .dn_val(val0), .dn_rdy(rdy0)
  );

  stream_burst_source #(.DATA_WIDTH(7), .LEN_WIDTH(8), .GAP(2)) u_gap2 (
    .clk(clk), .rst(rst), .start(start2), .first_val(fv2), .burst_len(len2),
    .busy(busy2), .done(done2), .beats_sent(beats2), .dn_bus(bus2),
    .dn_val(val2), .dn_rdy(rdy2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs only change 1 time unit after a rising edge, so what is seen on the
  // falling edge is exactly what the next rising edge will sample.
  always @(negedge clk) begin
    if (rst && val0 && rdy0) begin
      if (q0.size() == 0) chk("gap0_unexpected_beat", {25'd0, bus0}, 32'hFFFF_FFFF);
      else chk("gap0_beat_data", {25'd0, bus0}, {25'd0, q0.pop_front()});
    end
    if (rst && val2 && rdy2) begin
      if (q2.size() == 0) chk("gap2_unexpected_beat", {25'd0, bus2}, 32'hFFFF_FFFF);
      else chk("gap2_beat_data", {25'd0, bus2}, {25'd0, q2.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] wrap_exp [4];
    logic       gap_pat  [7];
    wrap_exp = '{8'h7E, 8'h7F, 8'h00, 8'h01};
    gap_pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    tick();
    chk("reset_val", val0, 0);
    chk("reset_bus", bus0, 0);
    chk("reset_busy", busy0, 0);
    chk("reset_done", done0, 0);
    chk("reset_beats", beats0, 0);
    tick();
    rst = 1'b1;
    tick();

    // Full-throughput burst with data wrap.
    fv0 = 7'h7E; len0 = 8'd4; rdy0 = 1'b1; start0 = 1'b1;
    for (int i = 0; i < 4; i++) q0.push_back(wrap_exp[i][6:0]);
    for (int c = 1; c <= 4; c++) begin
      tick();
      start0 = 1'b0;
      chk("t1_val", val0, 1);
      chk("t1_busy", busy0, 1);
      chk("t1_done", done0, 0);
      chk("t1_bus", bus0, {24'd0, wrap_exp[c-1]});
    end
    tick();
    chk("t1_done_pulse", done0, 1);
    chk("t1_val_low", val0, 0);
    chk("t1_busy_low", busy0, 0);
    chk("t1_beats", beats0, 4);
    tick();
    chk("t1_done_clear", done0, 0);
    chk("t1_beats_hold", beats0, 4);

    // Backpressure: word held while dn_rdy is low.
    fv0 = 7'd5; len0 = 8'd3; start0 = 1'b1;
    q0.push_back(7'd5); q0.push_back(7'd6); q0.push_back(7'd7);
    tick();
    start0 = 1'b0;
    chk("t2_first_bus", bus0, 5);
    for (int c = 2; c <= 4; c++) begin
      tick();
      rdy0 = 1'b0;
      chk("t2_hold_val", val0, 1);
      chk("t2_hold_bus", bus0, 6);
    end
    tick();
    rdy0 = 1'b1;
    chk("t2_release_bus", bus0, 6);
    tick();
    chk("t2_last_bus", bus0, 7);
    chk("t2_not_done_yet", done0, 0);
    tick();
    chk("t2_done", done0, 1);
    chk("t2_beats", beats0, 3);
    tick();

    // Zero-length burst.
    len0 = 8'd0; fv0 = 7'h33; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("t3_done", done0, 1);
    chk("t3_busy", busy0, 0);
    chk("t3_val", val0, 0);
    chk("t3_beats", beats0, 0);
    tick();
    chk("t3_done_clear", done0, 0);
    chk("t3_val_still_low", val0, 0);

    // Starts while busy ignored; start in the done cycle accepted.
    fv0 = 7'h20; len0 = 8'd4; start0 = 1'b1;
    for (int i = 0; i < 4; i++) q0.push_back(7'h20 + 7'(i));
    tick();
    start0 = 1'b0;
    tick();
    start0 = 1'b1; fv0 = 7'h55; len0 = 8'd9;
    tick();
    chk("t4_bus_c3", bus0, 8'h22);
    tick();
    start0 = 1'b0; fv0 = 7'h10; len0 = 8'd2;
    chk("t4_bus_c4", bus0, 8'h23);
    tick();
    chk("t4_done", done0, 1);
    chk("t4_beats", beats0, 4);
    start0 = 1'b1;
    q0.push_back(7'h10); q0.push_back(7'h11);
    tick();
    start0 = 1'b0;
    chk("t4_next_val", val0, 1);
    chk("t4_next_bus", bus0, 8'h10);
    chk("t4_next_busy", busy0, 1);
    tick();
    chk("t4_next_bus2", bus0, 8'h11);
    tick();
    chk("t4_next_done", done0, 1);
    chk("t4_next_beats", beats0, 2);
    tick();

    // GAP=2 instance.
    fv2 = 7'd0; len2 = 8'd3; rdy2 = 1'b1; start2 = 1'b1;
    q2.push_back(7'd0); q2.push_back(7'd1); q2.push_back(7'd2);
    for (int c = 1; c <= 7; c++) begin
      tick();
      start2 = 1'b0;
      chk("t5_val_pattern", val2, {31'd0, gap_pat[c-1]});
      chk("t5_busy", busy2, 1);
    end
    tick();
    chk("t5_done", done2, 1);
    chk("t5_beats", beats2, 3);
    tick();

    // Asynchronous reset during beat 2 of 5.
    fv0 = 7'h30; len0 = 8'd5; start0 = 1'b1;
    q0.push_back(7'h30);
    tick();
    start0 = 1'b0;
    tick();
    chk("t6_pre_beats", beats0, 1);
    chk("t6_pre_bus", bus0, 8'h31);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_val", val0, 0);
    chk("t6_rst_busy", busy0, 0);
    chk("t6_rst_done", done0, 0);
    chk("t6_rst_beats", beats0, 0);
    tick();
    rst = 1'b1;
    tick();
    fv0 = 7'h44; len0 = 8'd1; start0 = 1'b1;
    q0.push_back(7'h44);
    tick();
    start0 = 1'b0;
    chk("t6_post_val", val0, 1);
    chk("t6_post_bus", bus0, 8'h44);
    tick();
    chk("t6_post_done", done0, 1);
    chk("t6_post_beats", beats0, 1);
    chk("t6_post_val_low", val0, 0);
    tick();
    tick();

    chk("q0_drained", q0.size(), 0);
    chk("q2_drained", q2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
